uart_host_bridge: RTL
=====================

# uart_host_bridge

Host-side companion to the uartICE40 core. It generates the core's `bitxce` oversampling strobe and buffers transmit bytes in a FIFO, driving `load`/`d` under `txbusy` flow control. It also captures received bytes on `bytercvd`/`q` into a second FIFO. The host sees two valid/ready byte streams and a sticky overflow flag.

## Interface
- `DIVISOR`, 13: `clk` cycles per `bitxce` pulse; must be ≥2 (13 = 115200 baud ×8 at 12 MHz with SUBDIV16=0).
- `TXDEPTH_LOG2`, 4: transmit FIFO depth = 2**TXDEPTH_LOG2 bytes.
- `RXDEPTH_LOG2`, 4: receive FIFO depth = 2**RXDEPTH_LOG2 bytes.
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tx_data`  in  8  host byte to transmit.
- `tx_valid`  in  1  host offers `tx_data`.
- `tx_ready`  out  1  transmit FIFO not full.
- `rx_data`  out  8  head of receive FIFO.
- `rx_valid`  out  1  receive FIFO not empty.
- `rx_ready`  in  1  host consumes `rx_data`.
- `rx_overflow`  out  1  sticky: a received byte was dropped.
- `ovf_clr`  in  1  clears `rx_overflow`.
- `tx_idle`  out  1  TX FIFO empty, `load` low, `txbusy` low.
- `bitxce`  out  1  to core: one-cycle oversample strobe.
- `load`  out  1  to core: load transmit buffer.
- `d`  out  8  to core: byte accompanying `load`.
- `txbusy`  in  1  from core.
- `bytercvd`  in  1  from core: one-cycle received-byte strobe.
- `q`  in  8  from core: received byte, valid while `bytercvd` is high.

## Operation
- **Reset values:**
  - both FIFOs empty, so `tx_ready`=1 and `rx_valid`=0.
  - `load`=0, `d`=0, `bitxce`=0, divider count=0.
  - `rx_overflow`=0 and `tx_idle`=1 (with `txbusy` low).
  - `rst` does not reset the core; a byte already being shifted by the core completes.
- **Baud divider:**
  - count runs 0..DIVISOR-1 and wraps to 0.
  - `bitxce` is registered and high for exactly one cycle when the count wraps.
- **TX FIFO write:** on `tx_valid & tx_ready`. `tx_ready` = !full; it does not depend on a same-cycle pop.
- **TX issue:**
  - registered `load` is set for one cycle when the FIFO is non-empty, `txbusy`=0, and `load` was 0 in the previous cycle.
  - in that same edge, the FIFO head pops into registered `d`.
  - `d` holds its value until the next load.
  - back-to-back `load` never occurs.
- **RX FIFO write:**
  - on `bytercvd`, `q` is written if the FIFO is not full, or if it is full and `rx_valid & rx_ready` in the same cycle.
  - otherwise the byte is dropped, FIFO contents are unchanged, and `rx_overflow` is set.
- **RX read:**
  - show-ahead: `rx_data` is the head whenever `rx_valid`=1.
  - pop occurs on `rx_valid & rx_ready`.
- **Overflow flag:** `ovf_clr` clears `rx_overflow`. A new overflow in the same cycle as `ovf_clr` wins (flag stays 1).
- **FIFO pointers and counts:**
  - pointers are TXDEPTH_LOG2/RXDEPTH_LOG2 bits and wrap modulo depth.
  - counts are one bit wider, so full = count==depth.
  - a simultaneous push and pop leaves the count unchanged and is legal at full and at empty.
- **FIFO order:** both FIFOs preserve byte order; no byte is duplicated.

## Timing
- **`bitxce` cadence:** first pulse in cycle DIVISOR-1 after `rst` falls (the cycle `rst` is low is cycle 0); then every DIVISOR cycles.
- **TX latency:** write accepted in cycle c into an empty FIFO with `txbusy`=0 → `load`=1 with valid `d` in cycle c+1.
- **`txbusy` after load:** `txbusy` is 1 from cycle c+2; the bridge relies on this and never re-evaluates within the load-blocking cycle.
- **RX latency:** `bytercvd` in cycle c → `rx_valid`=1 and `rx_data`=q in cycle c+1. `rx_overflow` also rises in c+1 when the byte is dropped.
- **RX read timing:** pop in cycle c → next entry (or `rx_valid`=0) visible in cycle c+1.
- **Registered outputs:** every output is registered or decoded from registers only, with no combinational path from any input. `tx_idle` is the exception: it includes `txbusy` combinationally.
- **Reset mid-operation:**
  - `rst` high during a `load` cycle: `load` is 0 in the following cycle.
  - FIFO contents are discarded.
  - `bitxce` restarts its phase.

## Test plan
- **Reset:** assert `rst` 3 cycles → `tx_ready`=1, `rx_valid`=0, `load`=0, `rx_overflow`=0, `tx_idle`=1. With DIVISOR=13, `bitxce` pulses at cycles 12, 25, 38 after release.
- **Single TX:** write 0xA5 in cycle c, `txbusy`=0 → `load`=1 and `d`=0xA5 in c+1 only. Model `txbusy` high for 100 cycles → no further `load`; `tx_idle`=1 after `txbusy` falls.
- **TX fill/drain:** with `txbusy` held high, write 0x00..0x0F (depth 16) → `tx_ready`=0 after the 16th write. Release `txbusy` per byte → `d` sequence is 0x00..0x0F in order with no repeats.
- **RX burst:** pulse `bytercvd` with q=0x11,0x22,0x33 while `rx_ready`=0 → `rx_valid`=1 and `rx_data`=0x11. Read 3 with `rx_ready`=1 → 0x11,0x22,0x33, then `rx_valid`=0.
- **RX overflow:** fill 16 entries, then send `bytercvd` q=0x99 with `rx_ready`=0 → `rx_overflow`=1 and the head stays at the first byte. Repeat at full with `rx_ready`=1 in the same cycle → 0x99 stored and no new overflow. `ovf_clr` coinciding with a drop → flag stays 1.
- **Loopback:** wire the bridge to uartICE40 with `txpin` inverted to `rxpin`; send 0x55, 0xFF, 0x00 → the identical 3 bytes appear on `rx_data` in order with `rx_overflow`=0.

Source files
------------

// File: rtl/uart_host_bridge.sv
// Host-side bridge for the uartICE40 core: baud strobe generation,
// transmit/receive byte FIFOs with valid/ready streams and overflow flag.
module uart_host_bridge #(
  parameter int DIVISOR      = 13,
  parameter int TXDEPTH_LOG2 = 4,
  parameter int RXDEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_overflow,
  input  logic       ovf_clr,
  output logic       tx_idle,
  output logic       bitxce,
  output logic       load,
  output logic [7:0] d,
  input  logic       txbusy,
  input  logic       bytercvd,
  input  logic [7:0] q
);

  localparam int CW = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] CNT_PRE = CW'(DIVISOR - 2);
  localparam logic [CW-1:0] CNT_ONE = 1;

  localparam int TXD = 1 << TXDEPTH_LOG2;
  localparam int RXD = 1 << RXDEPTH_LOG2;
  localparam logic [TXDEPTH_LOG2:0] TX_FULL = {1'b1, {TXDEPTH_LOG2{1'b0}}};
  localparam logic [RXDEPTH_LOG2:0] RX_FULL = {1'b1, {RXDEPTH_LOG2{1'b0}}};
  localparam logic [TXDEPTH_LOG2-1:0] TX_P1 = 1;
  localparam logic [RXDEPTH_LOG2-1:0] RX_P1 = 1;
  localparam logic [TXDEPTH_LOG2:0] TX_C1 = 1;
  localparam logic [RXDEPTH_LOG2:0] RX_C1 = 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          bitxce_q, bitxce_d;

  logic [7:0]              tx_mem_q [TXD];
  logic [TXDEPTH_LOG2-1:0] tx_wptr_q, tx_wptr_d;
  logic [TXDEPTH_LOG2-1:0] tx_rptr_q, tx_rptr_d;
  logic [TXDEPTH_LOG2:0]   tx_cnt_q, tx_cnt_d;
  logic                    load_q, load_d;
  logic [7:0]              d_q, d_d;
  logic                    tx_empty, tx_push, tx_pop;

  logic [7:0]              rx_mem_q [RXD];
  logic [RXDEPTH_LOG2-1:0] rx_wptr_q, rx_wptr_d;
  logic [RXDEPTH_LOG2-1:0] rx_rptr_q, rx_rptr_d;
  logic [RXDEPTH_LOG2:0]   rx_cnt_q, rx_cnt_d;
  logic                    ovf_q, ovf_d;
  logic                    rx_full, rx_push, rx_pop, rx_drop;

  always_comb begin
    cnt_d    = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_ONE;
    // Registered strobe lands in the cycle where the count sits at its top.
    bitxce_d = (cnt_q == CNT_PRE);
  end

  assign tx_empty = (tx_cnt_q == '0);
  assign tx_ready = (tx_cnt_q != TX_FULL);
  assign tx_push  = tx_valid & tx_ready;

  always_comb begin
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    tx_cnt_d  = tx_cnt_q;
    load_d    = 1'b0;
    d_d       = d_q;
    // An empty FIFO forwards the incoming byte straight into d.
    tx_pop    = (!tx_empty | tx_push) & !txbusy & !load_q;
    if (tx_pop) begin
      load_d    = 1'b1;
      d_d       = tx_empty ? tx_data : tx_mem_q[tx_rptr_q];
      tx_rptr_d = tx_rptr_q + TX_P1;
    end
    if (tx_push) tx_wptr_d = tx_wptr_q + TX_P1;
    unique case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + TX_C1;
      2'b01:   tx_cnt_d = tx_cnt_q - TX_C1;
      default: tx_cnt_d = tx_cnt_q;
    endcase
  end

  assign rx_valid = (rx_cnt_q != '0);
  assign rx_full  = (rx_cnt_q == RX_FULL);
  assign rx_pop   = rx_valid & rx_ready;
  assign rx_push  = bytercvd & (!rx_full | rx_pop);
  assign rx_drop  = bytercvd & rx_full & !rx_pop;

  always_comb begin
    rx_wptr_d = rx_push ? rx_wptr_q + RX_P1 : rx_wptr_q;
    rx_rptr_d = rx_pop ? rx_rptr_q + RX_P1 : rx_rptr_q;
    unique case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + RX_C1;
      2'b01:   rx_cnt_d = rx_cnt_q - RX_C1;
      default: rx_cnt_d = rx_cnt_q;
    endcase
    ovf_d = rx_drop | (ovf_q & !ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      bitxce_q  <= 1'b0;
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
      load_q    <= 1'b0;
      d_q       <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bitxce_q  <= bitxce_d;
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      tx_cnt_q  <= tx_cnt_d;
      load_q    <= load_d;
      d_q       <= d_d;
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      rx_cnt_q  <= rx_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && tx_push) tx_mem_q[tx_wptr_q] <= tx_data;
    if (!rst && rx_push) rx_mem_q[rx_wptr_q] <= q;
  end

  assign rx_data     = rx_mem_q[rx_rptr_q];
  assign rx_overflow = ovf_q;
  assign tx_idle     = tx_empty & !load_q & !txbusy;
  assign bitxce      = bitxce_q;
  assign load        = load_q;
  assign d           = d_q;

endmodule
